// File: rtl/vga_dbg_pkg.sv
// Shared colours, glyph codes, a constant log2 helper and the 5x7 hex glyph source table.
package vga_dbg_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } colour_t;

  localparam colour_t COL_BLACK  = 8'h00;
  localparam colour_t COL_WHITE  = 8'hFF;
  localparam colour_t COL_YELLOW = 8'hFC;
  localparam colour_t COL_BAND   = 8'h08;

  typedef enum logic [4:0] {
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F,
    GLYPH_BLANK
  } glyph_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Row r (0 = top) of a 5x7 glyph, MSB is the leftmost pixel; row 7 and the blank code are empty.
  function automatic logic [4:0] font_row5(input logic [4:0] code, input logic [2:0] r);
    logic [34:0] g;
    case (code)
      5'h0: g = 35'b01110_10001_10011_10101_11001_10001_01110;
      5'h1: g = 35'b00100_01100_00100_00100_00100_00100_01110;
      5'h2: g = 35'b01110_10001_00001_00010_00100_01000_11111;
      5'h3: g = 35'b11110_00001_00001_01110_00001_00001_11110;
      5'h4: g = 35'b00010_00110_01010_10010_11111_00010_00010;
      5'h5: g = 35'b11111_10000_11110_00001_00001_10001_01110;
      5'h6: g = 35'b00110_01000_10000_11110_10001_10001_01110;
      5'h7: g = 35'b11111_00001_00010_00100_01000_01000_01000;
      5'h8: g = 35'b01110_10001_10001_01110_10001_10001_01110;
      5'h9: g = 35'b01110_10001_10001_01111_00001_00010_01100;
      5'hA: g = 35'b01110_10001_10001_11111_10001_10001_10001;
      5'hB: g = 35'b11110_10001_10001_11110_10001_10001_11110;
      5'hC: g = 35'b01110_10001_10000_10000_10000_10001_01110;
      5'hD: g = 35'b11100_10010_10001_10001_10001_10010_11100;
      5'hE: g = 35'b11111_10000_10000_11110_10000_10000_11111;
      5'hF: g = 35'b11111_10000_10000_11110_10000_10000_10000;
      default: g = '0;
    endcase
    if (r == 3'd7) return 5'b00000;
    return g[(6 - int'(r)) * 5 +: 5];
  endfunction

endpackage

// File: rtl/vga_debug_overlay_if.sv
// Timing, channel data and colour bundle between the video source and the overlay.
interface vga_debug_overlay_if #(
  parameter int NUM_CH = 17,
  parameter int DATA_W = 16
);
  logic                     valid;
  logic [10:0]              addr_row;
  logic [10:0]              addr_column;
  logic                     frame_start;
  logic                     freeze;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [2:0]               red;
  logic [2:0]               green;
  logic [1:0]               blue;

  modport master (
    output valid, addr_row, addr_column, frame_start, freeze, ch_data,
    input  red, green, blue
  );

  modport slave (
    input  valid, addr_row, addr_column, frame_start, freeze, ch_data,
    output red, green, blue
  );
endinterface

// File: rtl/vga_debug_overlay_hex_font_rom.sv
// Combinational glyph ROM: scales the 5x7 source font into a CHAR_W x CHAR_H cell, MSB = leftmost pixel.
module hex_font_rom
  import vga_dbg_pkg::*;
#(
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int ROW_BITS = (clog2(CHAR_H) > 0) ? clog2(CHAR_H) : 1
) (
  input  logic [4:0]          code,
  input  logic [ROW_BITS-1:0] grow,
  output logic [CHAR_W-1:0]   glyph_row
);

  int         src_row;
  logic [4:0] src_bits;

  always_comb begin
    glyph_row = '0;
    src_row   = (int'(grow) * 8) / CHAR_H;
    src_bits  = font_row5(code, 3'(src_row));
    // Source columns 5..7 form the inter-character gap.
    for (int c = 0; c < CHAR_W; c++) begin
      if ((c * 8) / CHAR_W < 5) glyph_row[CHAR_W-1-c] = src_bits[4 - (c * 8) / CHAR_W];
    end
  end

endmodule

// File: rtl/vga_debug_overlay.sv
// Hex debug text overlay with per-frame snapshot and freeze; CHANGE_HL_EN adds changed-line highlighting.
// Latency 3 cycles address-to-colour; free-running pipeline, never stalls, no backpressure.
module vga_debug_overlay
  import vga_dbg_pkg::*;
#(
  parameter int NUM_CH = 17,
  parameter int DATA_W = 16,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int X0     = 16,
  parameter int Y0     = 16
) (
  input  logic                clk,
  input  logic                reset,
  vga_debug_overlay_if.slave  bus
);

  localparam int NDIG   = DATA_W / 4;
  localparam int L      = 3 + NDIG;
  localparam int CW_LOG = clog2(CHAR_W);
  localparam int CH_LOG = clog2(CHAR_H);
  localparam int GCOL_B = (CW_LOG > 0) ? CW_LOG : 1;
  localparam int GROW_B = (CH_LOG > 0) ? CH_LOG : 1;

  localparam logic [11:0] ROW_LO = 12'(Y0);
  localparam logic [11:0] ROW_HI = 12'(Y0 + NUM_CH * CHAR_H);
  localparam logic [11:0] COL_LO = 12'(X0);
  localparam logic [11:0] COL_HI = 12'(X0 + L * CHAR_W);

  logic [DATA_W-1:0] snap [NUM_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
    end else if (bus.frame_start && !bus.freeze) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= bus.ch_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef CHANGE_HL_EN
  logic [DATA_W-1:0] prev [NUM_CH];
  logic [NUM_CH-1:0] changed;

  // prev always follows the outgoing snapshot, so a frozen display stops highlighting after one frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) prev[k] <= '0;
    end else if (bus.frame_start) begin
      for (int k = 0; k < NUM_CH; k++) prev[k] <= snap[k];
    end
  end

  always_comb begin
    changed = '0;
    for (int k = 0; k < NUM_CH; k++) changed[k] = (snap[k] != prev[k]);
  end
`endif

  // S1: box test and character-cell coordinates.
  logic [10:0] rel_row;
  logic [10:0] rel_col;
  logic        in_box;

  assign rel_row = bus.addr_row - 11'(Y0);
  assign rel_col = bus.addr_column - 11'(X0);
  assign in_box  = bus.valid
                && ({1'b0, bus.addr_row} >= ROW_LO) && ({1'b0, bus.addr_row} < ROW_HI)
                && ({1'b0, bus.addr_column} >= COL_LO) && ({1'b0, bus.addr_column} < COL_HI);

  logic              s1_vld;
  logic              s1_in_box;
  logic [5:0]        s1_line;
  logic [7:0]        s1_chr;
  logic [GROW_B-1:0] s1_grow;
  logic [GCOL_B-1:0] s1_gcol;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld    <= 1'b0;
      s1_in_box <= 1'b0;
      s1_line   <= '0;
      s1_chr    <= '0;
      s1_grow   <= '0;
      s1_gcol   <= '0;
    end else begin
      s1_vld    <= bus.valid;
      s1_in_box <= in_box;
      s1_line   <= 6'(rel_row >> CH_LOG);
      s1_chr    <= 8'(rel_col >> CW_LOG);
      s1_grow   <= GROW_B'(rel_row);
      s1_gcol   <= GCOL_B'(rel_col);
    end
  end

  // S2: pick the glyph code for this cell and look up its row.
  logic [DATA_W-1:0] word;
  logic [4:0]        code;
  logic [CHAR_W-1:0] glyph_row;
  logic [CHAR_W-1:0] glyph_rev;

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s1_line == 6'(k)) word = snap[k];
    end
    code = GLYPH_BLANK;
    if (s1_chr == 8'd0) begin
      code = {3'b000, s1_line[5:4]};
    end else if (s1_chr == 8'd1) begin
      code = {1'b0, s1_line[3:0]};
    end else begin
      for (int j = 0; j < NDIG; j++) begin
        if (s1_chr == 8'(3 + j)) code = {1'b0, word[(NDIG-1-j)*4 +: 4]};
      end
    end
  end

  hex_font_rom #(
    .CHAR_W   (CHAR_W),
    .CHAR_H   (CHAR_H),
    .ROW_BITS (GROW_B)
  ) u_font (
    .code      (code),
    .grow      (s1_grow),
    .glyph_row (glyph_row)
  );

  // Stored bit-reversed so S3 can index directly by gcol.
  always_comb begin
    glyph_rev = '0;
    for (int c = 0; c < CHAR_W; c++) glyph_rev[c] = glyph_row[CHAR_W-1-c];
  end

  logic              s2_vld;
  logic              s2_in_box;
  logic              s2_odd;
  logic [CHAR_W-1:0] s2_glyph;
  logic [GCOL_B-1:0] s2_gcol;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld    <= 1'b0;
      s2_in_box <= 1'b0;
      s2_odd    <= 1'b0;
      s2_glyph  <= '0;
      s2_gcol   <= '0;
    end else begin
      s2_vld    <= s1_vld;
      s2_in_box <= s1_in_box;
      s2_odd    <= s1_line[0];
      s2_glyph  <= glyph_rev;
      s2_gcol   <= s1_gcol;
    end
  end

  colour_t fg;

`ifdef CHANGE_HL_EN
  logic line_chg;
  logic s2_chg;

  always_comb begin
    line_chg = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s1_line == 6'(k)) line_chg = changed[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s2_chg <= 1'b0;
    else        s2_chg <= line_chg;
  end

  assign fg = s2_chg ? COL_YELLOW : COL_WHITE;
`else
  assign fg = COL_WHITE;
`endif

  // S3: pixel select and colour rules, registered to the outputs.
  logic    pix;
  colour_t colour;
  colour_t colour_q;

  assign pix = s2_glyph[s2_gcol];

  always_comb begin
    colour = COL_BLACK;
    if (s2_vld && s2_in_box) begin
      if (pix)         colour = fg;
      else if (s2_odd) colour = COL_BAND;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) colour_q <= COL_BLACK;
    else        colour_q <= colour;
  end

  assign bus.red   = colour_q.r;
  assign bus.green = colour_q.g;
  assign bus.blue  = colour_q.b;

endmodule
